// File: rtl/rf_spill_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rf_spill_if                                                  |
// | Description : Handshake, register-file and data-memory bundle for rf_spill.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface rf_spill_if;
    logic       start;
    logic       mode;
    logic [7:0] base_addr;
    logic [4:0] rf_ptr;
    logic [7:0] rf_rdata;
    logic       rf_we;
    logic [4:0] rf_wptr;
    logic [7:0] rf_wdata;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic       csum_err;

    modport master (
        output start, mode, base_addr, rf_rdata, mem_rdata,
        input  rf_ptr, rf_we, rf_wptr, rf_wdata, mem_addr, mem_we, mem_wdata,
               busy, done, csum_err
    );

    modport slave (
        input  start, mode, base_addr, rf_rdata, mem_rdata,
        output rf_ptr, rf_we, rf_wptr, rf_wdata, mem_addr, mem_we, mem_wdata,
               busy, done, csum_err
    );
endinterface
`default_nettype wire

// File: rtl/rf_spill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rf_spill                                                     |
// | Description : Saves/restores registers FIRST_REG..LAST_REG to/from memory, |
// |               one per cycle; optional XOR checksum via RF_SPILL_CHECKSUM_EN|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rf_spill #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 8
) (
    input  logic      clk,
    input  logic      reset,
    rf_spill_if.slave bus
);
    localparam logic [4:0] c_FIRST = 5'(FIRST_REG);
    localparam logic [4:0] c_LAST  = 5'(LAST_REG);
`ifdef RF_SPILL_CHECKSUM_EN
    localparam logic [7:0] c_NOFF  = 8'(LAST_REG - FIRST_REG + 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_CSUM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     r_state;
    logic [4:0] r_idx;
    logic       r_mode;
    logic [7:0] r_base;
`ifdef RF_SPILL_CHECKSUM_EN
    logic [7:0] r_acc;
    logic       r_csum_err;
`endif

    logic [7:0] w_off;
    assign w_off = 8'(r_idx - c_FIRST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_mode     <= 1'b0;
            r_base     <= '0;
`ifdef RF_SPILL_CHECKSUM_EN
            r_acc      <= '0;
            r_csum_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mode     <= bus.mode;
                        r_base     <= bus.base_addr;
                        r_idx      <= c_FIRST;
`ifdef RF_SPILL_CHECKSUM_EN
                        r_acc      <= '0;
                        r_csum_err <= 1'b0;
`endif
                        r_state    <= S_XFER;
                    end
                end
                S_XFER: begin
`ifdef RF_SPILL_CHECKSUM_EN
                    r_acc <= r_acc ^ (r_mode ? bus.mem_rdata : bus.rf_rdata);
`endif
                    if (r_idx == c_LAST) begin
`ifdef RF_SPILL_CHECKSUM_EN
                        r_state <= S_CSUM;
`else
                        r_state <= S_DONE;
`endif
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
`ifdef RF_SPILL_CHECKSUM_EN
                S_CSUM: begin
                    if (r_mode) begin
                        r_csum_err <= (bus.mem_rdata != r_acc);
                    end
                    r_state <= S_DONE;
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes are masked while reset is asserted so an aborted transfer
    // cannot commit a write on the reset edge itself.
    always_comb begin
        bus.rf_ptr    = '0;
        bus.rf_we     = 1'b0;
        bus.rf_wptr   = '0;
        bus.rf_wdata  = '0;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (!reset && r_state == S_XFER) begin
            bus.rf_ptr   = r_idx;
            bus.mem_addr = r_base + w_off;
            if (r_mode) begin
                bus.rf_we    = 1'b1;
                bus.rf_wptr  = r_idx;
                bus.rf_wdata = bus.mem_rdata;
            end else begin
                bus.mem_we    = 1'b1;
                bus.mem_wdata = bus.rf_rdata;
            end
        end
`ifdef RF_SPILL_CHECKSUM_EN
        else if (!reset && r_state == S_CSUM) begin
            bus.mem_addr = r_base + c_NOFF;
            if (!r_mode) begin
                bus.mem_we    = 1'b1;
                bus.mem_wdata = r_acc;
            end
        end
`endif
    end

    assign bus.busy = (r_state == S_XFER) || (r_state == S_CSUM);
    assign bus.done = (r_state == S_DONE);
`ifdef RF_SPILL_CHECKSUM_EN
    assign bus.csum_err = r_csum_err;
`else
    assign bus.csum_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/rf_spill.md
RF_SPILL -- requirements
Module: rf_spill

Interface
REQ-001 Parameter FIRST_REG, default 1: lowest register index transferred; register 0 is hard-wired zero and is never transferred.
REQ-002 Parameter LAST_REG, default 8: highest register index transferred; index 8 is the overflow flag slot. N = LAST_REG-FIRST_REG+1.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 reset  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  request pulse; sampled only in IDLE.
REQ-006 mode  in  1  0 = save (rf to memory), 1 = restore (memory to rf); latched at start.
REQ-007 base_addr  in  8  data-memory base address; latched at start.
REQ-008 rf_ptr  out  5  register-file read pointer.
REQ-009 rf_rdata  in  8  register-file read data, combinational from rf_ptr.
REQ-010 rf_we  out  1  register-file write enable.
REQ-011 rf_wptr  out  5  register-file write pointer.
REQ-012 rf_wdata  out  8  register-file write data.
REQ-013 mem_addr  out  8  data-memory address.
REQ-014 mem_we  out  1  data-memory write enable.
REQ-015 mem_wdata  out  8  data-memory write data.
REQ-016 mem_rdata  in  8  data-memory read data, combinational from mem_addr.
REQ-017 busy  out  1  high in XFER and CSUM states.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 csum_err  out  1  restore checksum mismatch flag.

Function
REQ-020 States: IDLE, XFER, CSUM, DONE. One-hot or binary encoding is permitted.
REQ-021 IDLE with start=1 at posedge: latch mode and base_addr, set idx=FIRST_REG, clear the XOR accumulator and csum_err, go to XFER. Otherwise stay in IDLE.
REQ-022 XFER: rf_ptr=idx and mem_addr=base_addr+(idx-FIRST_REG), both combinational; addition is modulo 256, so 0xFF+1 wraps to 0x00.
REQ-023 XFER, save: mem_we=1 and mem_wdata=rf_rdata; accumulator ^= rf_rdata.
REQ-024 XFER, restore: rf_we=1, rf_wptr=idx and rf_wdata=mem_rdata; accumulator ^= mem_rdata.
REQ-025 XFER: one register is transferred per cycle. After the cycle with idx==LAST_REG, go to CSUM if the checksum is enabled, else go to DONE. Otherwise idx increments.
REQ-026 DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE unconditionally.
REQ-027 Latency: done asserts N+1 cycles after the start edge without checksum, or N+2 cycles with checksum; for the default parameters this is 9 or 10.
REQ-028 start while busy or in DONE is ignored and is not queued.
REQ-029 Outside XFER and CSUM, rf_we=0, mem_we=0, and rf_ptr, rf_wptr, mem_addr and the data outputs are 0.
REQ-030 At most one of rf_we and mem_we is high in any cycle.

Reset
REQ-031 On reset=1 at posedge: state=IDLE, idx=0, accumulator=0, latched mode and base_addr=0, csum_err=0, and all outputs take their REQ-029 values with busy=0 and done=0.
REQ-032 Reset mid-transfer aborts the transfer. No write strobe asserts in the cycle after reset, and no done pulse is emitted.
REQ-033 Reset has priority over start in the same cycle.

Configuration
REQ-034 Macro RF_SPILL_CHECKSUM_EN. When defined, the CSUM state exists and behaves as follows:
- Save: mem_addr=base_addr+N and mem_we=1 with mem_wdata=accumulator.
- Restore: mem_addr=base_addr+N; csum_err is registered as (mem_rdata != accumulator) and holds until the next accepted start or reset.
REQ-035 When RF_SPILL_CHECKSUM_EN is not defined: XFER goes directly to DONE, no write occurs to base_addr+N, and csum_err is constant 0.

Verification
REQ-036 Registers 1..8 hold 0x11..0x88; save with base_addr=0x40 -> mem[0x40..0x47]=0x11..0x88, done at cycle 9 (10 with checksum), mem[0x48]=0x88 with checksum enabled (XOR of 0x11..0x88).
REQ-037 mem[0x40..0x48] as written by REQ-036; restore with base_addr=0x40 -> rf writes 0x11..0x88 to indices 1..8, csum_err=0.
REQ-038 Same setup with mem[0x43] corrupted to 0x00 before restore -> rf index 4 receives 0x00, and with checksum enabled csum_err=1 after done.
REQ-039 Save with base_addr=0xFC -> writes go to 0xFC..0xFF then 0x00..0x03; with checksum enabled the checksum goes to 0x04.
REQ-040 Assert reset 3 cycles into a save -> exactly 3 memory writes have occurred, busy=0 the next cycle, no done pulse; a later start runs a complete transfer.
REQ-041 start held high for 20 cycles -> the second transfer begins only after the DONE cycle; start pulses during busy produce no extra writes.
